grid8_flow_sequencer: RTL

- Time-multiplexes the 8-inlet reagent mux and the 8-stage cell-trap grid among 8 reagent requesters.
- Round-robin arbitrates the requesters, then drives the pneumatic control lines through a fixed break / fill / hold / flush sequence.
- Mux select lines c1..c6 are driven through mux_ctrl. Each stage's row-valve line d and column-valve line e are driven through d_ctrl and e_ctrl.
- Sits between the protocol host logic and the solenoid driver bank.
- Control polarity: 1 = pressurised = valve closed; 0 = valve open.

---
 rtl/grid8_ctrl_pkg.sv | 30 +++
 rtl/rr_arbiter8.sv | 25 ++
 rtl/grid8_flow_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/grid8_ctrl_pkg.sv
// Shared types and valve constants for the grid8 flow sequencer.
// Control polarity: 1 = pressurised = valve closed, 0 = valve open.
package grid8_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BREAK,
    ST_FILL,
    ST_HOLD,
    ST_FLUSH,
    ST_DONE
  } state_t;

  localparam logic       VALVE_OPEN       = 1'b0;
  localparam logic       VALVE_CLOSED     = 1'b1;
  localparam logic [5:0] ALL_CLOSED_MUX   = 6'h3F;
  localparam logic [7:0] ALL_CLOSED_STAGE = 8'hFF;

  // Each select bit opens one valve of its pair: c(2i+1) when 0, c(2i+2) when 1.
  function automatic logic [5:0] mux_open(input logic [2:0] sel);
    logic [5:0] m;
    m = ALL_CLOSED_MUX;
    for (int i = 0; i < 3; i++) begin
      if (sel[i]) m[2*i+1] = VALVE_OPEN;
      else        m[2*i]   = VALVE_OPEN;
    end
    return m;
  endfunction

endpackage

// File: rtl/rr_arbiter8.sv
// Combinational 8-way round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter8 (
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  input  logic       en,
  output logic       gnt_valid,
  output logic [2:0] gnt_id
);

  logic [2:0] idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = ptr;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (en && !gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
      end
    end
  end

endmodule

// File: rtl/grid8_flow_sequencer.sv
// Arbitrates 8 reagent requesters and sequences the mux and cell-trap grid valves
// through break / fill / hold / flush. All outputs are registered.
module grid8_flow_sequencer
  import grid8_ctrl_pkg::*;
#(
  parameter int unsigned BREAK_CYC = 4,
  parameter int unsigned FILL_CYC  = 16,
  parameter int unsigned HOLD_CYC  = 32,
  parameter int unsigned FLUSH_CYC = 16,
  parameter int          CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] stage_mask,
  input  logic       abort,
  output logic       busy,
  output logic       grant_valid,
  output logic [2:0] grant_id,
  output logic       done,
  output logic       aborted,
  output logic [5:0] mux_ctrl,
  output logic [7:0] d_ctrl,
  output logic [7:0] e_ctrl
);

  localparam logic [CNT_W-1:0] BREAK_LD = CNT_W'(BREAK_CYC - 1);
  localparam logic [CNT_W-1:0] FILL_LD  = CNT_W'(FILL_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] FLUSH_LD = CNT_W'(FLUSH_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [7:0]       mask_q, mask_d;
  logic [2:0]       grant_id_d;
  logic             grant_valid_d, aborted_d;
  logic [5:0]       mux_d;
  logic [7:0]       d_d, e_d;
  logic             arb_valid;
  logic [2:0]       arb_id;

  rr_arbiter8 u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .en        (state_q == ST_IDLE),
    .gnt_valid (arb_valid),
    .gnt_id    (arb_id)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d       = state_q;
    cnt_d         = cnt_q - CNT_W'(1);
    ptr_d         = ptr_q;
    mask_d        = mask_q;
    grant_id_d    = grant_id;
    grant_valid_d = 1'b0;
    aborted_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = cnt_q;
        if (arb_valid) begin
          state_d       = ST_BREAK;
          cnt_d         = BREAK_LD;
          grant_id_d    = arb_id;
          grant_valid_d = 1'b1;
          mask_d        = stage_mask;
          ptr_d         = arb_id + 3'd1;
        end
      end
      ST_BREAK, ST_FILL, ST_HOLD, ST_FLUSH: begin
        // Abort takes priority over a counter expiring in the same cycle.
        if (abort) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
        end else if (cnt_q == '0) begin
          unique case (state_q)
            ST_BREAK: begin state_d = ST_FILL;  cnt_d = FILL_LD;  end
            ST_FILL:  begin state_d = ST_HOLD;  cnt_d = HOLD_LD;  end
            ST_HOLD:  begin state_d = ST_FLUSH; cnt_d = FLUSH_LD; end
            default:  begin state_d = ST_DONE;  cnt_d = '0;       end
          endcase
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Valve lines follow the next state so they change on the same edge as the state.
  always_comb begin
    mux_d = ALL_CLOSED_MUX;
    d_d   = ALL_CLOSED_STAGE;
    e_d   = ALL_CLOSED_STAGE;
    unique case (state_d)
      ST_FILL: begin
        mux_d = mux_open(grant_id_d);
        d_d   = ~mask_d;
      end
      ST_FLUSH: e_d = ~mask_d;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      mask_q      <= '0;
      busy        <= 1'b0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      mux_ctrl    <= ALL_CLOSED_MUX;
      d_ctrl      <= ALL_CLOSED_STAGE;
      e_ctrl      <= ALL_CLOSED_STAGE;
    end else begin
      // NOTE: registered state uses non-blocking assignments so all flops update together.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      mask_q      <= mask_d;
      busy        <= (state_d != ST_IDLE);
      grant_valid <= grant_valid_d;
      grant_id    <= grant_id_d;
      done        <= (state_d == ST_DONE);
      aborted     <= aborted_d;
      mux_ctrl    <= mux_d;
      d_ctrl      <= d_d;
      e_ctrl      <= e_d;
    end
  end

endmodule
